// File: rtl/sub_1.sv
// Bit-serial decrement-by-one: LSB-first frames of W bits, each emitted minus one
// in the same cycle, plus a parallel copy of the decremented frame with an underflow flag.
module sub_1 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic         in_bit,
    output logic         out_valid,
    output logic         out_bit,
    output logic [W-1:0] result,
    output logic         result_valid,
    output logic         underflow
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] r_cnt;
    logic          r_brw;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_result;
    logic          r_underflow;
    logic          r_result_valid;

    logic          w_take;
    logic          w_first;
    logic          w_b;
    logic          w_dec;
    logic          w_brw_nxt;
    logic          w_last;
    logic [W-1:0]  w_acc_nxt;

    // A frame's bit 0 always starts with a borrow of one; later bits chain it.
    assign w_take    = in_valid & reset;
    assign w_first   = (r_cnt == '0) | in_sof;
    assign w_b       = w_first ? 1'b1 : r_brw;
    assign w_dec     = in_bit ^ w_b;
    assign w_brw_nxt = w_b & ~in_bit;
    assign w_last    = ~in_sof & (r_cnt == LAST);
    assign w_acc_nxt = {w_dec, r_acc[W-1:1]};

    assign out_valid    = w_take;
    assign out_bit      = w_take & w_dec;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_brw          <= 1'b0;
            r_acc          <= '0;
            r_result       <= '0;
            r_underflow    <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (in_valid) begin
                r_brw <= w_brw_nxt;
                r_acc <= w_acc_nxt;
                if (in_sof) begin
                    r_cnt <= (r_cnt == LAST) ? '0 : CW'(1);
                end else if (r_cnt == LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
                // Publish the completed frame; resynced partial frames never reach here.
                if (w_last) begin
                    r_result       <= w_acc_nxt;
                    r_underflow    <= w_brw_nxt;
                    r_result_valid <= 1'b1;
                end
            end
        end
    end

endmodule
